// File: rtl/mrelbp_ci_rn.sv
// MRELBP centre-intensity (CI) bit generator for a (2R+1)x(2R+1) window.
// Accepts one vertical K-pixel column per valid cycle, keeps a sliding
// K-column window sum along the line and compares it with centre*K*K.
// Three-stage pipeline: column reduce, window update, compare.
module mrelbp_ci_rn #(
  parameter int DATA_W = 8,
  parameter int RADIUS = 6,
  parameter int COLS   = 15,
  parameter int ROWS   = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_i,
  input  logic                                 sof_i,
  input  logic                                 mode_i,
  input  logic [(2*RADIUS+1)*DATA_W-1:0]       col_i,
  output logic                                 ci_o,
  output logic                                 valid_o,
  output logic                                 line_done_o,
  output logic                                 progress_done_o
);

  localparam int K     = 2 * RADIUS + 1;
  localparam int KK    = K * K;
  localparam int SUM_W = DATA_W + $clog2(KK);
  localparam int LINES = ROWS - 2 * RADIUS;
  localparam int XC_W  = $clog2(COLS);
  localparam int YC_W  = $clog2(LINES + 1);
  localparam logic [SUM_W-1:0] KK_S = SUM_W'(KK);

  // Column element unpack, j=0 is the top pixel.
  logic [DATA_W-1:0] pix [K];
  for (genvar gi = 0; gi < K; gi++) begin : g_unpack
    assign pix[gi] = col_i[gi*DATA_W +: DATA_W];
  end

  // Vertical sum of the incoming column.
  logic [SUM_W-1:0] colsum_d;
  always_comb begin
    colsum_d = '0;
    for (int j = 0; j < K; j++) begin
      colsum_d = colsum_d + SUM_W'(pix[j]);
    end
  end

  // Position of the incoming column; sof_i forces the start of a new frame.
  logic [XC_W-1:0] xc_q, xc_cur;
  logic [YC_W-1:0] yc_q, yc_cur;
  logic            last_col, last_line;
  always_comb begin
    xc_cur    = sof_i ? '0 : xc_q;
    yc_cur    = sof_i ? '0 : yc_q;
    last_col  = (xc_cur == XC_W'(COLS - 1));
    last_line = (yc_cur == YC_W'(LINES - 1));
  end

  // Stage 1: register column sum, centre pixel and position flags; advance counters.
  logic              s1_valid_q, s1_mode_q, s1_first_q, s1_full_q, s1_ld_q, s1_pd_q;
  logic [SUM_W-1:0]  s1_colsum_q;
  logic [DATA_W-1:0] s1_centre_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_full_q   <= 1'b0;
      s1_ld_q     <= 1'b0;
      s1_pd_q     <= 1'b0;
      s1_colsum_q <= '0;
      s1_centre_q <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_colsum_q <= colsum_d;
        s1_centre_q <= pix[RADIUS];
        s1_mode_q   <= mode_i;
        s1_first_q  <= (xc_cur == '0);
        s1_full_q   <= (xc_cur >= XC_W'(K - 1));
        s1_ld_q     <= last_col;
        s1_pd_q     <= last_col && last_line;
        if (last_col) begin
          xc_q <= '0;
          yc_q <= last_line ? '0 : yc_cur + YC_W'(1);
        end else begin
          xc_q <= xc_cur + XC_W'(1);
          yc_q <= yc_cur;
        end
      end
    end
  end

  // Stage 2: slide the window sum and the centre delay line on valid columns only.
  logic [SUM_W-1:0]  hist_q [K];
  logic [DATA_W-1:0] cen_q  [RADIUS+1];
  logic [SUM_W-1:0]  win_sum_q;
  logic              s2_valid_q, s2_mode_q, s2_ld_q, s2_pd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) hist_q[i] <= '0;
      for (int i = 0; i <= RADIUS; i++) cen_q[i] <= '0;
      win_sum_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_ld_q    <= 1'b0;
      s2_pd_q    <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q && s1_full_q;
      if (s1_valid_q) begin
        s2_mode_q <= s1_mode_q;
        s2_ld_q   <= s1_ld_q;
        s2_pd_q   <= s1_pd_q;
        // First column of a line starts from an empty history.
        win_sum_q <= s1_first_q ? s1_colsum_q
                                : win_sum_q + s1_colsum_q - hist_q[K-1];
        hist_q[0] <= s1_colsum_q;
        for (int i = 1; i < K; i++) hist_q[i] <= s1_first_q ? '0 : hist_q[i-1];
        cen_q[0] <= s1_centre_q;
        for (int i = 1; i <= RADIUS; i++) cen_q[i] <= cen_q[i-1];
      end
    end
  end

  // Stage 3: compare scaled centre with the window sum; ci_o holds between outputs.
  logic [SUM_W-1:0] scaled_d;
  assign scaled_d = SUM_W'(cen_q[RADIUS]) * KK_S;

  always_ff @(posedge clk) begin
    if (rst) begin
      ci_o            <= 1'b0;
      valid_o         <= 1'b0;
      line_done_o     <= 1'b0;
      progress_done_o <= 1'b0;
    end else begin
      valid_o         <= s2_valid_q;
      line_done_o     <= s2_valid_q && s2_ld_q;
      progress_done_o <= s2_valid_q && s2_pd_q;
      if (s2_valid_q) begin
        ci_o <= s2_mode_q ? (scaled_d > win_sum_q) : (scaled_d >= win_sum_q);
      end
    end
  end

endmodule
